// File: rtl/lvdc_acc_readout.sv
// lvdc_acc_readout: receives the LVDC serial accumulator readout.
// WDA rising edges mark slots, a PBV rising edge (seen on a slot) starts a
// frame, and WORD_W AI3V bits are shifted in MSB-first after SKIP_SLOTS
// ignored slots. Completed words go into a 2-entry FIFO drained over a
// valid/ready port.
module lvdc_acc_readout #(
    parameter int WORD_W     = 26,
    parameter int SKIP_SLOTS = 1
) (
    input  logic              SIM_CLK,
    input  logic              SIM_RST,
    input  logic              WDA,
    input  logic              PBV,
    input  logic              AI3V,
    input  logic              out_ready,
    input  logic              clr_err,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    output logic              overrun,
    output logic              frame_err,
    output logic [7:0]        frame_cnt
);

    localparam int SKW = (SKIP_SLOTS > 0) ? $clog2(SKIP_SLOTS + 1) : 1;
    localparam int BCW = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        SKIP,
        SHIFT
    } state_t;

    state_t            state, state_nx;
    logic              wda_q, pbv_q;
    logic              slot, start;
    logic [SKW-1:0]    skip_cnt, skip_cnt_nx;
    logic [BCW-1:0]    bit_cnt, bit_cnt_nx;
    // Only the bits received so far are kept; the newest bit joins at push time.
    logic [WORD_W-2:0] shreg, shreg_nx;
    logic [WORD_W-1:0] push_word;
    logic              push, abort;

    logic [WORD_W-1:0] mem [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        count;
    logic              pop, full, push_ok;

    assign slot      = WDA & ~wda_q;
    assign start     = slot & PBV & ~pbv_q;
    assign push_word = {shreg, AI3V};

    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid & out_ready;
    assign full      = (count == 2'd2);
    assign push_ok   = push & (~full | pop);

    // Edge detectors: WDA every clock, PBV only on slots.
    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            wda_q <= 1'b0;
            pbv_q <= 1'b0;
        end else begin
            wda_q <= WDA;
            if (slot) pbv_q <= PBV;
        end
    end

    // Frame FSM state, slot counters and shift register.
    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            state    <= IDLE;
            skip_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            state    <= state_nx;
            skip_cnt <= skip_cnt_nx;
            bit_cnt  <= bit_cnt_nx;
            shreg    <= shreg_nx;
        end
    end

    // Next-state logic; a start in any state (re)enters the skip phase.
    always_comb begin
        state_nx    = state;
        skip_cnt_nx = skip_cnt;
        bit_cnt_nx  = bit_cnt;
        shreg_nx    = shreg;
        push        = 1'b0;
        abort       = 1'b0;
        if (start) begin
            abort = (state != IDLE);
            if (SKIP_SLOTS == 0) begin
                state_nx   = SHIFT;
                bit_cnt_nx = BCW'(WORD_W);
            end else begin
                state_nx    = SKIP;
                skip_cnt_nx = SKW'(SKIP_SLOTS);
            end
        end else if (slot) begin
            case (state)
                SKIP: begin
                    skip_cnt_nx = skip_cnt - SKW'(1);
                    if (skip_cnt == SKW'(1)) begin
                        state_nx   = SHIFT;
                        bit_cnt_nx = BCW'(WORD_W);
                    end
                end
                SHIFT: begin
                    shreg_nx   = push_word[WORD_W-2:0];
                    bit_cnt_nx = bit_cnt - BCW'(1);
                    if (bit_cnt == BCW'(1)) begin
                        push     = 1'b1;
                        state_nx = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Two-entry output FIFO; a pop frees room for a same-cycle push.
    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_word;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push_ok, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Frame counter and sticky error flags; setting beats clearing.
    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            frame_cnt <= 8'd0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (push_ok) frame_cnt <= frame_cnt + 8'd1;
            overrun   <= (push & ~push_ok) | (overrun & ~clr_err);
            frame_err <= abort | (frame_err & ~clr_err);
        end
    end

endmodule
